// File: rtl/adder_tree_accum_if.sv
// adder_tree_accum_if: groups the sample input, flush and result handshake of
// the frame accumulator.
//   slave  : the accumulator's view (takes in_valid/in_sum/flush/out_ready,
//            drives in_ready/out_valid/out_sum/out_count/out_ovf)
//   master : the surrounding logic's view (the opposite directions)
interface adder_tree_accum_if #(
    parameter int IN_WIDTH  = 10,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_sum;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_sum, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/adder_tree_accum.sv
// adder_tree_accum: sums FRAME_LEN consecutive adder-tree results (or fewer,
// when a frame is flushed early) into a wide accumulator and presents each
// finished frame through a single-entry valid/ready output register.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous, active-high reset; discards any partial frame
//   bus  - adder_tree_accum_if.slave:
//          in_valid/in_ready/in_sum : tree sum feed
//          flush                    : close the current frame early
//          out_valid/out_ready      : result handshake
//          out_sum/out_count/out_ovf: frame total, sample count, overflow
//
// Build option: define ACCUM_SATURATE_EN to clamp the accumulator at
// 2^ACC_WIDTH-1 on overflow and report a sticky overflow flag on out_ovf.
// Without it the accumulator wraps and out_ovf is tied low.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no samples in the current frame (acc = 0, cnt = 0)
// ACCUM | 1 <= cnt < FRAME_LEN samples accumulated
// HOLD  | frame finished but output register busy; feed stalled
module adder_tree_accum #(
    parameter int ADDER_WIDTH = 7,
    parameter int IN_WIDTH    = ADDER_WIDTH + 3,
    parameter int FRAME_LEN   = 16,
    parameter int ACC_WIDTH   = 16,
    parameter int CNT_WIDTH   = $clog2(FRAME_LEN) + 1
) (
    input logic               clk,
    input logic               rst,
    adder_tree_accum_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_WIDTH-1:0] FRAME_CNT = CNT_WIDTH'(FRAME_LEN);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] out_sum_q;
    logic [CNT_WIDTH-1:0] out_count_q;

    logic                 accept;
    logic                 out_free;
    logic                 close;
    logic [ACC_WIDTH-1:0] acc_add;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [ACC_WIDTH-1:0] frame_acc;
    logic [CNT_WIDTH-1:0] frame_cnt;

`ifdef ACCUM_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    logic                 ovf;
    logic                 out_ovf_q;
    logic                 frame_ovf;
    logic [ACC_WIDTH:0]   sum_ext;

    assign sum_ext   = {1'b0, acc} + {1'b0, ACC_WIDTH'(bus.in_sum)};
    // Once clamped, the frame stays at full scale until it closes.
    assign acc_add   = (ovf || sum_ext[ACC_WIDTH]) ? ACC_MAX : sum_ext[ACC_WIDTH-1:0];
    assign frame_ovf = ovf || (accept && sum_ext[ACC_WIDTH]);
    assign bus.out_ovf = out_ovf_q;
`else
    assign acc_add     = acc + ACC_WIDTH'(bus.in_sum);
    assign bus.out_ovf = 1'b0;
`endif

    // in_ready depends on state only so upstream never sees a loop through in_valid.
    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;

    assign accept   = bus.in_valid && (state != HOLD);
    assign out_free = !out_valid_q || bus.out_ready;
    assign cnt_inc  = cnt + CNT_WIDTH'(1);

    // A lone flush only closes a non-empty frame; zero-count results never exist.
    assign close     = accept ? ((cnt_inc == FRAME_CNT) || bus.flush)
                              : (bus.flush && (state == ACCUM));
    assign frame_acc = accept ? acc_add : acc;
    assign frame_cnt = accept ? cnt_inc : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
`ifdef ACCUM_SATURATE_EN
            ovf         <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    // Output register is occupied on entry to HOLD, so a
                    // handshake here frees it and the held frame moves in.
                    if (out_valid_q && bus.out_ready) begin
                        out_sum_q   <= acc;
                        out_count_q <= cnt;
`ifdef ACCUM_SATURATE_EN
                        out_ovf_q   <= ovf;
                        ovf         <= 1'b0;
`endif
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    if (close) begin
                        if (out_free) begin
                            out_valid_q <= 1'b1;
                            out_sum_q   <= frame_acc;
                            out_count_q <= frame_cnt;
`ifdef ACCUM_SATURATE_EN
                            out_ovf_q   <= frame_ovf;
                            ovf         <= 1'b0;
`endif
                            acc         <= '0;
                            cnt         <= '0;
                            state       <= IDLE;
                        end else begin
                            acc   <= frame_acc;
                            cnt   <= frame_cnt;
`ifdef ACCUM_SATURATE_EN
                            ovf   <= frame_ovf;
`endif
                            state <= HOLD;
                        end
                    end else begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                        if (accept) begin
                            acc   <= acc_add;
                            cnt   <= cnt_inc;
`ifdef ACCUM_SATURATE_EN
                            ovf   <= frame_ovf;
`endif
                            state <= ACCUM;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_accum.sv
// Bench for adder_tree_accum: a 16-bit instance for the frame, flush,
// back-pressure, reset and back-to-back scenarios and a 12-bit instance for
// overflow. Expected frames are queued as stimulus is driven and popped when
// the DUT hands a result off.
module tb_adder_tree_accum;

    typedef struct {
        logic [15:0] sum;
        logic [4:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    adder_tree_accum_if #(.IN_WIDTH(10), .ACC_WIDTH(16), .CNT_WIDTH(5)) bus0 ();
    adder_tree_accum_if #(.IN_WIDTH(10), .ACC_WIDTH(12), .CNT_WIDTH(5)) bus1 ();

    adder_tree_accum #(.ADDER_WIDTH(7), .FRAME_LEN(16), .ACC_WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    adder_tree_accum #(.ADDER_WIDTH(7), .FRAME_LEN(16), .ACC_WIDTH(12)) u_dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic exp_t mk(input int s, input int c, input bit o);
        exp_t r;
        r.sum = s[15:0];
        r.cnt = c[4:0];
        r.ovf = o;
        return r;
    endfunction

    // Scoreboard: every handshake on either output must match the next queued frame.
    always @(negedge clk) begin
        if (!rst && bus0.out_valid && bus0.out_ready) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL sb16_unexpected got sum=%0d cnt=%0d with no frame expected",
                         bus0.out_sum, bus0.out_count);
            end else begin
                e0 = q0.pop_front();
                if (bus0.out_sum !== e0.sum || bus0.out_count !== e0.cnt || bus0.out_ovf !== e0.ovf) begin
                    bad++;
                    $display("FAIL sb16_result got sum=%0d cnt=%0d ovf=%b expected sum=%0d cnt=%0d ovf=%b",
                             bus0.out_sum, bus0.out_count, bus0.out_ovf, e0.sum, e0.cnt, e0.ovf);
                end
            end
        end
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL sb12_unexpected got sum=%0d cnt=%0d with no frame expected",
                         bus1.out_sum, bus1.out_count);
            end else begin
                e1 = q1.pop_front();
                if ({4'b0, bus1.out_sum} !== e1.sum || bus1.out_count !== e1.cnt || bus1.out_ovf !== e1.ovf) begin
                    bad++;
                    $display("FAIL sb12_result got sum=%0d cnt=%0d ovf=%b expected sum=%0d cnt=%0d ovf=%b",
                             bus1.out_sum, bus1.out_count, bus1.out_ovf, e1.sum, e1.cnt, e1.ovf);
                end
            end
        end
    end

    // Drives one sample on the 16-bit instance; it must be accepted at once.
    task automatic send(input logic [9:0] v, input logic fl);
        bus0.in_valid = 1'b1;
        bus0.in_sum   = v;
        bus0.flush    = fl;
        @(negedge clk);
        total++;
        if (bus0.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_on_sample got=%b expected=1 (sample %0d)", bus0.in_ready, v);
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.flush    = 1'b0;
    endtask

    task automatic drain0;
        int n;
        n = 0;
        while (q0.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL drain16_timeout got pending=%0d expected pending=0", q0.size());
        end
        total++;
        if (bus0.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain16_idle got out_valid=%b expected=0", bus0.out_valid);
        end
    endtask

    task automatic drain1;
        int n;
        n = 0;
        while (q1.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL drain12_timeout got pending=%0d expected pending=0", q1.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus0.out_valid !== 1'b0 || bus0.out_sum !== 16'd0 || bus0.out_count !== 5'd0 || bus0.out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b sum=%0d cnt=%0d ovf=%b expected all 0",
                     bus0.out_valid, bus0.out_sum, bus0.out_count, bus0.out_ovf);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b expected 1/0",
                     bus0.in_ready, bus0.out_valid);
        end
    endtask

    task automatic test_full_frame;
        bus0.out_ready = 1'b1;
        q0.push_back(mk(136, 16, 1'b0));
        for (int i = 1; i <= 16; i++) begin
            send(10'(i), 1'b0);
        end
        total++;
        if (bus0.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL full_frame_latency got out_valid=%b expected=1", bus0.out_valid);
        end
        drain0();
    endtask

    task automatic test_flush;
        bus0.out_ready = 1'b1;
        q0.push_back(mk(600, 3, 1'b0));
        send(10'd100, 1'b0);
        send(10'd200, 1'b0);
        send(10'd300, 1'b1);
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_count !== 5'd3) begin
            bad++;
            $display("FAIL flush_close got valid=%b cnt=%0d expected 1/3", bus0.out_valid, bus0.out_count);
        end
        drain0();
        bus0.flush = 1'b1;
        @(posedge clk);
        #1;
        bus0.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus0.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_idle got out_valid=%b expected=0", bus0.out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_pressure;
        bus0.out_ready = 1'b0;
        q0.push_back(mk(16368, 16, 1'b0));
        q0.push_back(mk(16368, 16, 1'b0));
        for (int i = 0; i < 32; i++) begin
            send(10'd1023, 1'b0);
        end
        total++;
        if (bus0.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_in_ready got=%b expected=0", bus0.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus0.out_valid !== 1'b1 || bus0.out_sum !== 16'd16368 || bus0.out_count !== 5'd16 || bus0.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable got valid=%b sum=%0d cnt=%0d in_ready=%b expected 1/16368/16/0",
                         bus0.out_valid, bus0.out_sum, bus0.out_count, bus0.in_ready);
            end
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
        drain0();
        total++;
        if (bus0.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got in_ready=%b expected=1", bus0.in_ready);
        end
    endtask

    task automatic test_overflow;
        bus1.out_ready = 1'b1;
`ifdef ACCUM_SATURATE_EN
        q1.push_back(mk(4095, 16, 1'b1));
`else
        q1.push_back(mk(4080, 16, 1'b0));
`endif
        for (int i = 0; i < 16; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_sum   = 10'd1023;
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b0;
        drain1();
    endtask

    task automatic test_reset_mid_frame;
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(10'd1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            send(10'd7, 1'b0);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (bus0.out_valid !== 1'b0 || bus0.out_sum !== 16'd0 || bus0.out_count !== 5'd0 || bus0.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_async got valid=%b sum=%0d cnt=%0d in_ready=%b expected 0/0/0/1",
                     bus0.out_valid, bus0.out_sum, bus0.out_count, bus0.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        q0.push_back(mk(32, 16, 1'b0));
        for (int i = 0; i < 16; i++) begin
            send(10'd2, 1'b0);
        end
        drain0();
    endtask

    task automatic test_simultaneous;
        bus0.out_ready = 1'b0;
        q0.push_back(mk(48, 16, 1'b0));
        q0.push_back(mk(80, 16, 1'b0));
        for (int i = 0; i < 16; i++) begin
            send(10'd3, 1'b0);
        end
        for (int i = 0; i < 15; i++) begin
            send(10'd5, 1'b0);
        end
        bus0.out_ready = 1'b1;
        send(10'd5, 1'b0);
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_sum !== 16'd80 || bus0.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL simultaneous_load got valid=%b sum=%0d in_ready=%b expected 1/80/1",
                     bus0.out_valid, bus0.out_sum, bus0.in_ready);
        end
        drain0();
    endtask

    task automatic test_back_to_back;
        bus0.out_ready = 1'b1;
        q0.push_back(mk(136, 16, 1'b0));
        q0.push_back(mk(32, 16, 1'b0));
        q0.push_back(mk(9, 1, 1'b0));
        for (int i = 1; i <= 16; i++) begin
            send(10'(i), 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            send(10'd2, 1'b0);
        end
        send(10'd9, 1'b1);
        drain0();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.in_sum    = '0;
        bus0.flush     = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_sum    = '0;
        bus1.flush     = 1'b0;
        bus1.out_ready = 1'b0;

        test_reset();
        test_full_frame();
        test_flush();
        test_back_pressure();
        test_overflow();
        test_reset_mid_frame();
        test_simultaneous();
        test_back_to_back();

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL final_queues got pending16=%0d pending12=%0d expected 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree_accum.md
# adder_tree_accum

Frame accumulator that sits directly downstream of the 3-level adder tree. It consumes one tree sum per accepted cycle and adds FRAME_LEN consecutive sums into a wide accumulator. Each completed (or flushed) frame is presented through a single-entry output register with a valid/ready handshake. Back-pressure stalls the tree feed only when a finished frame cannot be handed off.

## Interface
Parameters:
- ADDER_WIDTH, 7: leaf operand width of the upstream tree.
- IN_WIDTH, ADDER_WIDTH+3: width of the incoming tree sum (full 3-level result).
- FRAME_LEN, 16: samples per frame, 1..256.
- ACC_WIDTH, 16: accumulator and result width, ≥ IN_WIDTH.
- CNT_WIDTH, $clog2(FRAME_LEN)+1: sample-count width.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_sum is valid this cycle.
- in_ready  out  1  block accepts in_sum this cycle.
- in_sum  in  IN_WIDTH  unsigned tree sum.
- flush  in  1  close the current frame early; single-cycle pulse.
- out_valid  out  1  out_sum/out_count/out_ovf hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- out_sum  out  ACC_WIDTH  frame total.
- out_count  out  CNT_WIDTH  samples in the frame, 1..FRAME_LEN.
- out_ovf  out  1  frame overflowed ACC_WIDTH.

## Operation
- Accept = in_valid & in_ready. Output free = !out_valid | out_ready.
- States:
  - IDLE: acc = 0, cnt = 0.
  - ACCUM: 1 ≤ cnt < FRAME_LEN.
  - HOLD: frame complete, output register occupied.
- IDLE/ACCUM, on accept:
  - acc_next = acc + in_sum (zero-extended); cnt_next = cnt + 1.
  - Frame closes when cnt_next == FRAME_LEN, or when flush is asserted in the same cycle. The accepted sample is included.
- flush without accept:
  - In ACCUM, closes the frame with its current cnt.
  - In IDLE (cnt == 0), ignored. No zero-count result is ever produced.
- On close:
  - If output free: load out_sum/out_count/out_ovf, set out_valid, go to IDLE with acc = 0 and cnt = 0.
  - Otherwise: keep the completed acc/cnt and go to HOLD.
- HOLD:
  - in_ready = 0; flush ignored.
  - When out_valid & out_ready: load the held frame into the output register (out_valid stays 1) and go to IDLE.
- in_ready = (state != HOLD). It is combinational from state only, never from in_valid.
- out_valid clears on out_ready when no new frame loads that cycle. Output fields are stable while out_valid & !out_ready.
- Overflow is detected as carry out of ACC_WIDTH on any add within the frame. The sticky flag clears when a new frame starts.
- Reset, any state, mid-frame included: state = IDLE, acc = 0, cnt = 0. Outputs: out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0. in_ready = 1 after reset deasserts. The partial frame is discarded.

## Timing
- Latency: out_valid rises on the clock edge that accepts the closing sample or flush. It is visible in the next cycle.
- Throughput: one sample per cycle sustained. Back-to-back frames have no bubble while out_ready = 1.
- With out_ready held low, at most one extra frame completes into HOLD. in_ready then drops on the next cycle.
- Handshake rules:
  - Upstream may hold in_valid indefinitely. in_sum must be stable until accepted.
  - The output side obeys AXI-stream-style valid/ready: no combinational path from out_ready to out_valid.

## Configuration
- ACCUM_SATURATE_EN defined:
  - On overflow, acc clamps to 2^ACC_WIDTH−1 for the rest of the frame.
  - out_ovf reports the sticky overflow flag.
- ACCUM_SATURATE_EN undefined:
  - acc wraps modulo 2^ACC_WIDTH.
  - out_ovf is tied to 0 and no overflow logic is built.

## Test plan
- Full frame (FRAME_LEN=16, ACC_WIDTH=16): in_sum = 1..16 on consecutive cycles, out_ready=1 -> one result: out_sum=136, out_count=16, out_ovf=0. in_ready stays 1 throughout.
- Flush (FRAME_LEN=16, ACC_WIDTH=16): in_sum 100, 200, 300, with flush on the third sample -> out_sum=600, out_count=3. A flush alone in IDLE produces no output.
- Back-pressure: two full frames of in_sum=1023 with out_ready=0 -> first result 16368/16 held; second frame enters HOLD; in_ready=0. Raise out_ready -> results delivered in order, then in_ready=1.
- Overflow (ACC_WIDTH=12): 16 × 1023.
  - Macro defined -> out_sum=4095, out_ovf=1.
  - Macro undefined -> out_sum=4080, out_ovf=0.
- Reset mid-frame: 5 samples accepted, pulse rst asynchronously -> out_valid=0 immediately. The next frame of 16 × 2 yields out_sum=32 with no residue.
- Simultaneous events: the 16th sample arrives in the same cycle out_ready drains the previous result -> new result loads, out_valid stays 1, no sample lost.
